// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    ROUND,
    LAST,
    DONE
  } state_e;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Number of rounds for a key-size code; the illegal code maps to 0.
  function automatic logic [3:0] nr_of(input logic [1:0] key_size);
    logic [3:0] nr;
    case (key_size)
      KS_128:  nr = 4'(NR_128);
      KS_192:  nr = 4'(NR_192);
      KS_256:  nr = 4'(NR_256);
      default: nr = 4'd0;
    endcase
    return nr;
  endfunction

  // Only codes 00/01/10 name a real key size.
  function automatic logic key_legal(input logic [1:0] key_size);
    return key_size != 2'b11;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and strobe bundle between the round sequencer and its neighbours.
interface aes_round_ctrl_if #(
  parameter int RND_W = 4,
  parameter int CNT_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       key_size;
  logic             abort;
  logic             ks_valid;
  logic             ks_load;
  logic             ks_step;
  logic             dp_load;
  logic             dp_first;
  logic             dp_round;
  logic             dp_last;
  logic [RND_W-1:0] round_idx;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] op_count;

  // Requester / key scheduler / consumer side.
  modport master (
    output req_valid, key_size, abort, ks_valid, res_ready,
    input  req_ready, ks_load, ks_step, dp_load, dp_first, dp_round, dp_last,
           round_idx, res_valid, busy, err, op_count
  );

  // Sequencer side.
  modport slave (
    input  req_valid, key_size, abort, ks_valid, res_ready,
    output req_ready, ks_load, ks_step, dp_load, dp_first, dp_round, dp_last,
           round_idx, res_valid, busy, err, op_count
  );

endinterface

// File: rtl/aes_round_ctrl_cnt.sv
// Round counter: cleared between operations, stepped once per consumed round key.
module aes_round_cnt #(
  parameter int RND_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [RND_W-1:0] nr_i,
  output logic [RND_W-1:0] round_idx_o,
  output logic             is_last_m1_o,
  output logic             is_last_o
);

  logic [RND_W-1:0] cnt_q;

  // Count up on each step; the count saturates at Nr so it can never run past the final round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != nr_i)) begin
      cnt_q <= cnt_q + RND_W'(1);
    end
  end

  assign round_idx_o  = cnt_q;
  assign is_last_m1_o = (cnt_q + RND_W'(1)) == nr_i;
  assign is_last_o    = cnt_q == nr_i;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the shared iterative AES round datapath and its key scheduler.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int RND_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.slave  bus
);

  state_e           state_q;
  logic [RND_W-1:0] nr_q;
  logic             req_ready_q;
  logic             busy_q;
  logic             res_valid_q;
  logic             err_q;
  logic [CNT_W-1:0] op_count_q;

  logic             accept;
  logic             abort_act;
  logic             cnt_clr;
  logic             cnt_en;
  logic [RND_W-1:0] round_idx;
  logic             is_last_m1;
  logic             is_last;

  logic             dp_load_d;
  logic             dp_first_d;
  logic             dp_round_d;
  logic             dp_last_d;
  logic             ks_load_d;
  logic             ks_step_d;

  // req_ready_q is high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept    = req_ready_q && bus.req_valid;
  assign abort_act = bus.abort && (state_q != IDLE);

  // Strobes follow ks_valid in the same cycle, so they are decoded from the state register
  // rather than registered; abort silences every strobe in its cycle.
  always_comb begin
    dp_load_d  = 1'b0;
    dp_first_d = 1'b0;
    dp_round_d = 1'b0;
    dp_last_d  = 1'b0;
    ks_load_d  = 1'b0;
    ks_step_d  = 1'b0;
    if (!abort_act) begin
      case (state_q)
        LOAD: begin
          dp_load_d = 1'b1;
          ks_load_d = 1'b1;
        end
        INIT: begin
          dp_first_d = bus.ks_valid;
          ks_step_d  = bus.ks_valid;
        end
        ROUND: begin
          dp_round_d = bus.ks_valid;
          ks_step_d  = bus.ks_valid;
        end
        LAST: begin
          dp_last_d = bus.ks_valid && is_last;
        end
        default: begin
          dp_load_d = 1'b0;
        end
      endcase
    end
  end

  assign cnt_en  = ks_step_d;
  assign cnt_clr = abort_act || (state_q == LOAD) || ((state_q == DONE) && bus.res_ready);

  aes_round_cnt #(
    .RND_W(RND_W)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .nr_i         (nr_q),
    .round_idx_o  (round_idx),
    .is_last_m1_o (is_last_m1),
    .is_last_o    (is_last)
  );

  // Main FSM with its registered handshake/status outputs and the saturating operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nr_q        <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      op_count_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (abort_act) begin
        state_q     <= IDLE;
        req_ready_q <= 1'b1;
        busy_q      <= 1'b0;
        res_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (key_legal(bus.key_size)) begin
                nr_q        <= RND_W'(nr_of(bus.key_size));
                state_q     <= LOAD;
                req_ready_q <= 1'b0;
                busy_q      <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            state_q <= INIT;
          end
          INIT: begin
            if (bus.ks_valid) begin
              state_q <= ROUND;
            end
          end
          ROUND: begin
            if (bus.ks_valid && is_last_m1) begin
              state_q <= LAST;
            end
          end
          LAST: begin
            if (dp_last_d) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end
          end
          DONE: begin
            if (bus.res_ready) begin
              state_q     <= IDLE;
              res_valid_q <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              if (op_count_q != {CNT_W{1'b1}}) begin
                op_count_q <= op_count_q + CNT_W'(1);
              end
            end
          end
          default: begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.err       = err_q;
  assign bus.op_count  = op_count_q;
  assign bus.round_idx = round_idx;
  assign bus.dp_load   = dp_load_d;
  assign bus.dp_first  = dp_first_d;
  assign bus.dp_round  = dp_round_d;
  assign bus.dp_last   = dp_last_d;
  assign bus.ks_load   = ks_load_d;
  assign bus.ks_step   = ks_step_d;

endmodule
